alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 50 +++++
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request/ALU/response signal bundle for alu_sequencer
//
// Purpose: groups the request handshake, the ALU operand/select/result path and
// the response handshake of alu_sequencer into one interface.
//
// Signals:
//   req_valid/req_ready      request handshake (requester -> sequencer)
//   req_op[2:0]              operation select carried with the request
//   req_a/req_b[7:0]         request operands
//   alu_a/alu_b[7:0]         registered operands driven to the ALU function units
//   alu_sel[2:0]             registered select driven to the ALU result mux
//   alu_z[7:0]               output of the external ALU result mux
//   rsp_valid/rsp_ready      response handshake (sequencer -> consumer)
//   rsp_result[7:0]          captured alu_z
//   rsp_zero                 captured result equals 8'h00
//   rsp_op[2:0]              op code that produced the response
//   busy                     operation in flight (SETTLE or RESP)
//   op_count[7:0]            completed response handshakes, wrapping
//
// Modports: slave = the sequencer, master = requester/consumer/ALU environment.
interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_z;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic [2:0] rsp_op;
  logic       busy;
  logic [7:0] op_count;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_z, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_zero,
           rsp_op, busy, op_count
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_z, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_zero,
           rsp_op, busy, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences one ALU operation per request with a settle delay
//
// Purpose: accepts a request, holds its operands and select on the ALU inputs for
// SETTLE_CYCLES cycles, then captures the ALU result mux output into a response
// register that is held until the consumer takes it. A new request may be accepted
// on the same edge the response completes, so back-to-back traffic has no bubble.
//
// Parameters:
//   SETTLE_CYCLES  cycles operands/select are held before sampling alu_z (1..8)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    alu_sequencer_if.slave (request, ALU path, response, status)
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  // Counter loads SETTLE_CYCLES-1 and samples when it reaches zero, so values
  // up to 8 fit in three bits.
  localparam logic [2:0] CNT_INIT = 3'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [2:0] alu_sel_q;
  logic [7:0] rsp_result_q;
  logic       rsp_zero_q;
  logic [2:0] rsp_op_q;
  logic       rsp_valid_q;
  logic       busy_q;
  logic [7:0] op_count_q;

  logic rsp_done;
  logic req_ready;
  logic accept;

  assign rsp_done  = (state_q == S_RESP) && bus.rsp_ready;
  // Ready is combinational so a request can ride the response handshake edge;
  // it is gated by reset so nothing looks acceptable while reset is held.
  assign req_ready = !reset && ((state_q == S_IDLE) || rsp_done);
  assign accept    = bus.req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_sel_q    <= 3'b000;
      rsp_result_q <= 8'h00;
      rsp_zero_q   <= 1'b0;
      rsp_op_q     <= 3'b000;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= 8'h00;
    end else begin
      // Operands stay on the ALU until the next acceptance; a completed
      // response does not clear them.
      if (accept) begin
        alu_a_q   <= bus.req_a;
        alu_b_q   <= bus.req_b;
        alu_sel_q <= bus.req_op;
      end

      if (rsp_done) begin
        op_count_q <= op_count_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_SETTLE;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            rsp_result_q <= bus.alu_z;
            rsp_zero_q   <= (bus.alu_z == 8'h00);
            rsp_op_q     <= alu_sel_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_done) begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
              state_q <= S_SETTLE;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= 3'd0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard testbench for alu_sequencer
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer_if b2 ();
  alu_sequencer_if b1 ();
  alu_sequencer_if b8 ();

  alu_sequencer #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  alu_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  alu_sequencer #(.SETTLE_CYCLES(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));

  // Environment ALU result mux.
  function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = a ^ b;
      3'd5:    alu_f = {a[6:0], 1'b0};
      3'd6:    alu_f = b;
      default: alu_f = a;
    endcase
  endfunction

  assign b2.alu_z = alu_f(b2.alu_sel, b2.alu_a, b2.alu_b);
  assign b1.alu_z = alu_f(b1.alu_sel, b1.alu_a, b1.alu_b);
  assign b8.alu_z = alu_f(b8.alu_sel, b8.alu_a, b8.alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: {result[7:0], zero, op[2:0]}
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  int          mon_hs = 0;

  always @(negedge clk) begin
    if (reset) begin
      mon_hs = 0;
    end else if (b2.rsp_valid && b2.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got result %0h with no expected entry", b2.rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_result", 32'(b2.rsp_result), 32'(mon_e[11:4]));
        check("rsp_zero", 32'(b2.rsp_zero), 32'(mon_e[3]));
        check("rsp_op", 32'(b2.rsp_op), 32'(mon_e[2:0]));
        check("op_count_at_hs", 32'(b2.op_count), 32'(mon_hs & 255));
      end
      mon_hs++;
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input bit push, output int acc);
    if (push) exp_q.push_back({exp, (exp == 8'h00), op});
    b2.req_op    = op;
    b2.req_a     = a;
    b2.req_b     = b;
    b2.req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b2.req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    b2.req_valid = 1'b0;
    if (acc < 0) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !b2.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp_valid();
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (b2.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_rsp_valid", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_b2b[4];
    int lat;
    int rel_cyc;
    bit seen;

    reset = 1'b0;
    b2.req_valid = 0; b2.req_op = 0; b2.req_a = 0; b2.req_b = 0; b2.rsp_ready = 1;
    b1.req_valid = 0; b1.req_op = 0; b1.req_a = 0; b1.req_b = 0; b1.rsp_ready = 1;
    b8.req_valid = 0; b8.req_op = 0; b8.req_a = 0; b8.req_b = 0; b8.rsp_ready = 1;
    #2 reset = 1'b1;
    #1;
    check("rst_req_ready", 32'(b2.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    check("rst_busy", 32'(b2.busy), 32'd0);
    check("rst_op_count", 32'(b2.op_count), 32'd0);
    check("rst_alu_a", 32'(b2.alu_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic add with latency 2
    send(3'd0, 8'h12, 8'h34, 8'h46, 1'b1, acc);
    check("basic_busy", 32'(b2.busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (b2.rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency_s2", 32'(lat), 32'd2);
    drain();
    check("basic_op_count", 32'(b2.op_count), 32'd1);

    // Zero flag
    send(3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, acc);
    drain();

    // Backpressure: response held while a new request waits
    b2.rsp_ready = 1'b0;
    send(3'd1, 8'h50, 8'h20, 8'h30, 1'b1, acc);
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      b2.req_valid = 1'b1;
      b2.req_op    = 3'd3;
      b2.req_a     = 8'h01 << i;
      b2.req_b     = 8'h80;
      @(negedge clk);
      check("bp_result", 32'(b2.rsp_result), 32'h30);
      check("bp_op", 32'(b2.rsp_op), 32'd1);
      check("bp_alu_a", 32'(b2.alu_a), 32'h50);
      check("bp_req_ready", 32'(b2.req_ready), 32'd0);
      check("bp_rsp_valid", 32'(b2.rsp_valid), 32'd1);
    end
    exp_q.push_back({8'h90, 1'b0, 3'd3});
    @(posedge clk);
    #1 b2.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    b2.req_valid = 1'b0;
    check("bp_accept_alu_a", 32'(b2.alu_a), 32'h10);
    check("bp_accept_sel", 32'(b2.alu_sel), 32'd3);
    check("bp_accept_busy", 32'(b2.busy), 32'd1);
    check("bp_accept_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    drain();

    // Back-to-back: acceptance rides each response handshake
    send(3'd4, 8'hF0, 8'hFF, 8'h0F, 1'b1, acc_b2b[0]);
    send(3'd5, 8'h81, 8'h00, 8'h02, 1'b1, acc_b2b[1]);
    send(3'd6, 8'h00, 8'h5A, 8'h5A, 1'b1, acc_b2b[2]);
    send(3'd7, 8'hC3, 8'h11, 8'hC3, 1'b1, acc_b2b[3]);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc_b2b[i] - acc_b2b[i-1]), 32'd3);
    drain();
    check("b2b_op_count", 32'(b2.op_count), 32'd8);

    // Reset one cycle after acceptance
    send(3'd0, 8'h01, 8'h01, 8'h02, 1'b0, acc);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(b2.busy), 32'd0);
    check("mid_rst_req_ready", 32'(b2.req_ready), 32'd0);
    check("mid_rst_alu_a", 32'(b2.alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(b2.alu_b), 32'd0);
    check("mid_rst_alu_sel", 32'(b2.alu_sel), 32'd0);
    check("mid_rst_result", 32'(b2.rsp_result), 32'd0);
    check("mid_rst_zero", 32'(b2.rsp_zero), 32'd0);
    check("mid_rst_rsp_op", 32'(b2.rsp_op), 32'd0);
    check("mid_rst_op_count", 32'(b2.op_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b2.rsp_valid || b2.busy) seen = 1'b1;
    end
    check("no_rsp_after_release", 32'(seen), 32'd0);

    // First acceptance on the first edge after release
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel_cyc = cyc;
    send(3'd3, 8'h0C, 8'h03, 8'h0F, 1'b1, acc);
    check("first_accept_edge", 32'(acc), 32'(rel_cyc + 1));
    drain();
    check("post_rst_op_count", 32'(b2.op_count), 32'd1);

    // Wrap: 255 more handshakes bring op_count to 256 -> 0
    for (int i = 0; i < 255; i++) begin
      if (i == 254) begin
        drain();
        check("op_count_ff", 32'(b2.op_count), 32'hFF);
      end
      send(3'd0, 8'(i), 8'h01, 8'(i + 1), 1'b1, acc);
    end
    drain();
    check("op_count_wrap", 32'(b2.op_count), 32'h00);

    // SETTLE_CYCLES = 1
    @(posedge clk);
    #1;
    b1.req_valid = 1'b1; b1.req_op = 3'd0; b1.req_a = 8'h12; b1.req_b = 8'h34;
    @(posedge clk);
    #1 b1.req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (b1.rsp_valid) begin
        lat = k - 1;
        break;
      end
      @(posedge clk);
      #1;
      if (b1.rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency_s1", 32'(lat), 32'd1);
    check("s1_result", 32'(b1.rsp_result), 32'h46);
    @(posedge clk);
    #1;
    check("s1_op_count", 32'(b1.op_count), 32'd1);

    // SETTLE_CYCLES = 8
    b8.req_valid = 1'b1; b8.req_op = 3'd0; b8.req_a = 8'h12; b8.req_b = 8'h34;
    @(posedge clk);
    #1 b8.req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (b8.rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency_s8", 32'(lat), 32'd8);
    check("s8_result", 32'(b8.rsp_result), 32'h46);
    check("s8_zero", 32'(b8.rsp_zero), 32'd0);
    @(posedge clk);
    #1;
    check("s8_op_count", 32'(b8.op_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
